// File: rtl/daf_pkg.sv
// Shared types and constants for the digital-audio-effects sequencer slice.
// Stage indices match the bit positions of swch_mode_en / stage_start / stage_done.
package daf_pkg;

  localparam int DAF_DATA_W = 32;

  localparam int STG_FLANGER = 3;
  localparam int STG_CLIP    = 2;
  localparam int STG_COMP    = 1;
  localparam int STG_FADER   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_START,
    ST_WAIT,
    ST_OUT
  } daf_seq_state_t;

endpackage

// File: rtl/daf_mem_clearer.sv
// Delay-memory clearer: on start, sweeps clr_addr 0..CLR_DEPTH-1 with clr_we high.
// done is high during the final word so the caller can leave on the same edge.
module daf_mem_clearer #(
  parameter int ADDR_W    = 10,
  parameter int CLR_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLR_DEPTH - 1);

  logic              active_q, active_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    active_d = active_q;
    addr_d   = addr_q;
    if (start) begin
      active_d = 1'b1;
      addr_d   = '0;
    end else if (active_q) begin
      if (addr_q == LAST_ADDR) begin
        active_d = 1'b0;
        addr_d   = '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      active_q <= active_d;
      addr_q   <= addr_d;
    end
  end

  assign done     = active_q && (addr_q == LAST_ADDR);
  assign clr_we   = active_q;
  assign clr_addr = addr_q;

endmodule

// File: rtl/daf_effect_sequencer.sv
// Per-frame effect-chain controller: walks flanger, clip, comp, fader in order,
// bypasses disabled or hung stages, and schedules delay-memory clears between frames.
module daf_effect_sequencer
  import daf_pkg::*;
#(
  parameter int DATA_W    = DAF_DATA_W,
  parameter int ADDR_W    = 10,
  parameter int CLR_DEPTH = 1024,
  parameter int TIMEOUT   = 24
) (
  input  logic              tb_clk,
  input  logic              tb_n_rst,
  input  logic              frame_valid,
  input  logic [DATA_W-1:0] frame_in,
  input  logic [3:0]        swch_mode_en,
  input  logic              mem_clr,
  input  logic              err_clr,
  output logic [3:0]        stage_start,
  output logic [DATA_W-1:0] stage_data,
  input  logic [3:0]        stage_done,
  input  logic [DATA_W-1:0] stage_result,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [DATA_W-1:0] frame_out,
  output logic              frame_out_valid,
  output logic              busy,
  output logic              overrun,
  output logic [3:0]        stage_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  daf_seq_state_t    state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        en_q, en_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              clr_pending_q, clr_pending_d;
  logic [DATA_W-1:0] frame_out_q, frame_out_d;
  logic              overrun_q, overrun_d;
  logic [3:0]        stage_err_q, stage_err_d;
  logic [3:0]        err_set;
  logic              ovr_set;
  logic              clr_start;
  logic              clr_done;

  // A pending clear always beats a new frame, so the clearer starts from IDLE only.
  assign clr_start = (state_q == ST_IDLE) && clr_pending_q;

  daf_mem_clearer #(
    .ADDR_W    (ADDR_W),
    .CLR_DEPTH (CLR_DEPTH)
  ) u_clearer (
    .clk      (tb_clk),
    .rst_n    (tb_n_rst),
    .start    (clr_start),
    .done     (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    en_d          = en_q;
    work_d        = work_q;
    wdog_d        = wdog_q;
    clr_pending_d = clr_pending_q;
    frame_out_d   = frame_out_q;
    err_set       = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (clr_pending_q) begin
          state_d = ST_CLEAR;
        end else if (frame_valid) begin
          work_d  = frame_in;
          en_d    = swch_mode_en;
          idx_d   = 2'(STG_FLANGER);
          state_d = ST_SCAN;
        end
      end
      ST_CLEAR: begin
        if (clr_done) begin
          clr_pending_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (en_q[idx_q]) begin
          state_d = ST_START;
        end else if (idx_q != 2'(STG_FADER)) begin
          idx_d = idx_q - 2'd1;
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done on the last allowed cycle still counts; the watchdog only fires without one.
        if (stage_done[idx_q] || (wdog_q == WD_W'(TIMEOUT - 1))) begin
          if (stage_done[idx_q]) begin
            work_d = stage_result;
          end else begin
            err_set[idx_q] = 1'b1;
          end
          if (idx_q != 2'(STG_FADER)) begin
            idx_d   = idx_q - 2'd1;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_OUT;
          end
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (mem_clr) begin
      clr_pending_d = 1'b1;
    end

    if (state_d == ST_OUT) begin
      frame_out_d = work_d;
    end

    ovr_set     = frame_valid && ((state_q != ST_IDLE) || clr_pending_q);
    overrun_d   = ovr_set | (overrun_q & ~err_clr);
    stage_err_d = err_set | (stage_err_q & {4{~err_clr}});
  end

  always_ff @(posedge tb_clk or negedge tb_n_rst) begin
    if (!tb_n_rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      en_q          <= '0;
      work_q        <= '0;
      wdog_q        <= '0;
      clr_pending_q <= 1'b1;
      frame_out_q   <= '0;
      overrun_q     <= 1'b0;
      stage_err_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      en_q          <= en_d;
      work_q        <= work_d;
      wdog_q        <= wdog_d;
      clr_pending_q <= clr_pending_d;
      frame_out_q   <= frame_out_d;
      overrun_q     <= overrun_d;
      stage_err_q   <= stage_err_d;
    end
  end

  assign stage_start     = (state_q == ST_START) ? (4'b0001 << idx_q) : 4'b0000;
  assign stage_data      = work_q;
  assign frame_out       = frame_out_q;
  assign frame_out_valid = (state_q == ST_OUT);
  assign busy            = (state_q != ST_IDLE);
  assign overrun         = overrun_q;
  assign stage_err       = stage_err_q;

endmodule

// File: tb/tb_daf_effect_sequencer.sv
// Bench for daf_effect_sequencer: a frame-level timeline model predicts every output
// each cycle from the stage latencies the bench's own stubs are told to use.
module tb_daf_effect_sequencer;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 10;
  localparam int CLR_DEPTH = 1024;
  localparam int TIMEOUT   = 24;
  localparam int RING      = 256;

  logic              tb_clk = 1'b0;
  logic              tb_n_rst = 1'b0;
  logic              frame_valid = 1'b0;
  logic [DATA_W-1:0] frame_in = '0;
  logic [3:0]        swch_mode_en = '0;
  logic              mem_clr = 1'b0;
  logic              err_clr = 1'b0;
  logic [3:0]        stage_start;
  logic [DATA_W-1:0] stage_data;
  logic [3:0]        stage_done = '0;
  logic [DATA_W-1:0] stage_result = '0;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] frame_out;
  logic              frame_out_valid;
  logic              busy;
  logic              overrun;
  logic [3:0]        stage_err;

  always #5 tb_clk = ~tb_clk;

  daf_effect_sequencer #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .CLR_DEPTH (CLR_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .tb_clk          (tb_clk),
    .tb_n_rst        (tb_n_rst),
    .frame_valid     (frame_valid),
    .frame_in        (frame_in),
    .swch_mode_en    (swch_mode_en),
    .mem_clr         (mem_clr),
    .err_clr         (err_clr),
    .stage_start     (stage_start),
    .stage_data      (stage_data),
    .stage_done      (stage_done),
    .stage_result    (stage_result),
    .clr_we          (clr_we),
    .clr_addr        (clr_addr),
    .frame_out       (frame_out),
    .frame_out_valid (frame_out_valid),
    .busy            (busy),
    .overrun         (overrun),
    .stage_err       (stage_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = -1;

  // Timeline of future per-cycle events, indexed by absolute cycle modulo RING.
  logic [3:0]        start_exp [RING];
  logic [DATA_W-1:0] start_data[RING];
  logic [3:0]        done_drv  [RING];
  logic [DATA_W-1:0] res_drv   [RING];
  logic [3:0]        wait_mask [RING];
  logic [3:0]        err_set   [RING];
  bit                outv      [RING];
  logic [DATA_W-1:0] outval    [RING];

  int                busy_until = -1;
  int                clr_base = -1;
  int                clr_last = -1;
  bit                pend = 1'b1;
  logic              m_ovr = 1'b0;
  logic [3:0]        m_err = '0;
  logic [DATA_W-1:0] m_fout = '0;

  // Per-stage latency for the next accepted frame: 0 means the stub never answers.
  int lat_cfg[4];
  bit rand_lat = 1'b0;

  int                dut_out_cyc = -1;
  logic [DATA_W-1:0] dut_out_val = '0;
  logic [3:0]        start_log[$];

  function automatic int ri(input int c);
    return c % RING;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic planFrame(input int c, input logic [DATA_W-1:0] fin, input logic [3:0] en);
    int t;
    int s;
    int d;
    logic [DATA_W-1:0] w;
    t = c + 1;
    w = fin;
    for (int k = 3; k >= 0; k--) begin
      if (en[k]) begin
        if (rand_lat) begin
          case ($urandom_range(0, 9))
            0:       lat_cfg[k] = 0;
            1:       lat_cfg[k] = TIMEOUT;
            default: lat_cfg[k] = int'($urandom_range(1, 6));
          endcase
        end
        s = t + 1;
        start_exp[ri(s)]  = start_exp[ri(s)] | 4'(1 << k);
        start_data[ri(s)] = w;
        d = lat_cfg[k];
        if (d == 0) begin
          for (int j = 1; j <= TIMEOUT; j++) wait_mask[ri(s + j)] = wait_mask[ri(s + j)] | 4'(1 << k);
          err_set[ri(s + TIMEOUT)] = err_set[ri(s + TIMEOUT)] | 4'(1 << k);
          t = s + TIMEOUT + 1;
        end else begin
          for (int j = 1; j <= d; j++) wait_mask[ri(s + j)] = wait_mask[ri(s + j)] | 4'(1 << k);
          w = w + 32'd1;
          done_drv[ri(s + d)] = done_drv[ri(s + d)] | 4'(1 << k);
          res_drv[ri(s + d)]  = w;
          t = s + d + 1;
        end
      end else begin
        t = t + 1;
      end
    end
    outv[ri(t)]   = 1'b1;
    outval[ri(t)] = w;
    busy_until    = t;
  endtask

  task automatic applyStimulus(input bit fv, input logic [DATA_W-1:0] fin, input logic [3:0] en,
                               input bit mc, input bit ec);
    logic [3:0] spur;
    int i;
    i = ri(cyc);
    frame_valid  = fv;
    frame_in     = fin;
    swch_mode_en = en;
    mem_clr      = mc;
    err_clr      = ec;
    spur = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
    stage_done   = done_drv[i] | (spur & ~wait_mask[i] & ~done_drv[i]);
    stage_result = (done_drv[i] != 4'b0000) ? res_drv[i] : $urandom;
  endtask

  task automatic checkOutput();
    int  i;
    bit  clearing;
    i = ri(cyc);
    if (outv[i]) m_fout = outval[i];
    clearing = (clr_base >= 0) && (cyc >= clr_base) && (cyc <= clr_last);
    check("busy", 32'(busy), 32'(cyc <= busy_until));
    check("frame_out_valid", 32'(frame_out_valid), 32'(outv[i]));
    check("frame_out", frame_out, m_fout);
    check("stage_start", 32'(stage_start), 32'(start_exp[i]));
    if (start_exp[i] != 4'b0000) check("stage_data", stage_data, start_data[i]);
    check("clr_we", 32'(clr_we), 32'(clearing));
    if (clearing) check("clr_addr", 32'(clr_addr), 32'(cyc - clr_base));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("stage_err", 32'(stage_err), 32'(m_err));
    if (frame_out_valid) begin
      dut_out_cyc = cyc;
      dut_out_val = frame_out;
    end
    if (stage_start != 4'b0000) start_log.push_back(stage_start);
  endtask

  task automatic modelUpdate(input bit fv, input logic [DATA_W-1:0] fin, input logic [3:0] en,
                             input bit mc, input bit ec);
    bit idle_now;
    bit ovr_set;
    int i;
    i = ri(cyc);
    idle_now = (cyc > busy_until);
    ovr_set  = fv && (!idle_now || pend);
    if (idle_now) begin
      if (pend) begin
        clr_base   = cyc + 1;
        clr_last   = cyc + CLR_DEPTH;
        busy_until = clr_last;
      end else if (fv) begin
        planFrame(cyc, fin, en);
      end
    end
    if (cyc == clr_last) pend = mc;
    else                 pend = pend | mc;
    m_err = err_set[i] | (ec ? 4'b0000 : m_err);
    m_ovr = ovr_set | (ec ? 1'b0 : m_ovr);
    start_exp[i] = '0;
    done_drv[i]  = '0;
    wait_mask[i] = '0;
    err_set[i]   = '0;
    outv[i]      = 1'b0;
  endtask

  task automatic doCycle(input bit fv, input logic [DATA_W-1:0] fin, input logic [3:0] en,
                         input bit mc, input bit ec);
    applyStimulus(fv, fin, en, mc, ec);
    @(negedge tb_clk);
    checkOutput();
    modelUpdate(fv, fin, en, mc, ec);
  endtask

  task automatic runCycle(input bit fv, input logic [DATA_W-1:0] fin, input logic [3:0] en,
                          input bit mc, input bit ec);
    @(posedge tb_clk);
    #1;
    cyc++;
    doCycle(fv, fin, en, mc, ec);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) runCycle(1'b0, '0, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < RING; i++) begin
      start_exp[i] = '0; start_data[i] = '0; done_drv[i] = '0; res_drv[i] = '0;
      wait_mask[i] = '0; err_set[i] = '0; outv[i] = 1'b0; outval[i] = '0;
    end
    for (int k = 0; k < 4; k++) lat_cfg[k] = 1;

    for (int i = 0; i < 3; i++) begin
      @(negedge tb_clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_clr_we", 32'(clr_we), 32'd0);
      check("rst_start", 32'(stage_start), 32'd0);
      check("rst_out_valid", 32'(frame_out_valid), 32'd0);
      check("rst_err", 32'({overrun, stage_err}), 32'd0);
    end

    // Reset release is cycle 0; the sweep occupies cycles 1..1024.
    @(posedge tb_clk);
    #1;
    tb_n_rst = 1'b1;
    cyc = 0;
    doCycle(1'b0, '0, 4'b0000, 1'b0, 1'b0);
    runCycle(1'b0, '0, 4'b0000, 1'b0, 1'b0);
    check("clr_first_addr", 32'(clr_addr), 32'd0);
    while (cyc < 1024) runCycle(1'b0, '0, 4'b0000, 1'b0, 1'b0);
    check("clr_last_addr", 32'(clr_addr), 32'd1023);
    check("clr_busy_last", 32'(busy), 32'd1);
    runCycle(1'b0, '0, 4'b0000, 1'b0, 1'b0);
    check("clr_busy_drop", 32'(busy), 32'd0);
    idleCycles(3);

    start_log.delete();
    c0 = cyc + 1;
    runCycle(1'b1, 32'h1234ABCD, 4'b0000, 1'b0, 1'b0);
    idleCycles(8);
    check("bypass_latency", 32'(dut_out_cyc - c0), 32'd5);
    check("bypass_value", dut_out_val, 32'h1234ABCD);
    check("bypass_no_start", 32'(start_log.size()), 32'd0);

    start_log.delete();
    for (int k = 0; k < 4; k++) lat_cfg[k] = 1;
    c0 = cyc + 1;
    runCycle(1'b1, 32'h1234ABCD, 4'b1111, 1'b0, 1'b0);
    idleCycles(16);
    check("chain_latency", 32'(dut_out_cyc - c0), 32'd13);
    check("chain_value", dut_out_val, 32'h1234ABD1);
    check("chain_starts", 32'(start_log.size()), 32'd4);
    if (start_log.size() == 4) begin
      check("chain_order0", 32'(start_log[0]), 32'h8);
      check("chain_order1", 32'(start_log[1]), 32'h4);
      check("chain_order2", 32'(start_log[2]), 32'h2);
      check("chain_order3", 32'(start_log[3]), 32'h1);
    end

    lat_cfg[2] = 0;
    c0 = cyc + 1;
    runCycle(1'b1, 32'hCAFE0042, 4'b0100, 1'b0, 1'b0);
    idleCycles(33);
    check("hung_latency", 32'(dut_out_cyc - c0), 32'd30);
    check("hung_value", dut_out_val, 32'hCAFE0042);
    check("hung_err", 32'(stage_err), 32'h4);
    runCycle(1'b0, '0, 4'b0000, 1'b0, 1'b1);
    runCycle(1'b0, '0, 4'b0000, 1'b0, 1'b0);
    check("hung_err_cleared", 32'(stage_err), 32'h0);

    for (int k = 0; k < 4; k++) lat_cfg[k] = 1;
    c0 = cyc + 1;
    runCycle(1'b1, 32'h00010000, 4'b1111, 1'b0, 1'b0);
    idleCycles(2);
    runCycle(1'b1, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);
    idleCycles(14);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_first_value", dut_out_val, 32'h00010004);
    check("ovr_first_latency", 32'(dut_out_cyc - c0), 32'd13);
    runCycle(1'b0, '0, 4'b0000, 1'b0, 1'b1);
    idleCycles(2);

    // Fader-only frame with latency 3: WAIT spans c0+6..c0+8, OUT at c0+9, CLEAR from c0+11.
    lat_cfg[0] = 3;
    c0 = cyc + 1;
    runCycle(1'b1, 32'h55AA0001, 4'b0001, 1'b0, 1'b0);
    idleCycles(5);
    runCycle(1'b0, '0, 4'b0000, 1'b1, 1'b0);
    idleCycles(5);
    check("clrwait_value", dut_out_val, 32'h55AA0002);
    check("clrwait_latency", 32'(dut_out_cyc - c0), 32'd9);
    runCycle(1'b1, 32'h0BADF00D, 4'b1111, 1'b0, 1'b0);
    check("clrwait_clearing", 32'(clr_we), 32'd1);
    runCycle(1'b0, '0, 4'b0000, 1'b0, 1'b0);
    check("clrwait_ovr", 32'(overrun), 32'd1);
    idleCycles(CLR_DEPTH + 4);
    runCycle(1'b0, '0, 4'b0000, 1'b0, 1'b1);

    rand_lat = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      runCycle($urandom_range(0, 11) == 0, $urandom, 4'($urandom),
               $urandom_range(0, 799) == 0, $urandom_range(0, 49) == 0);
    end
    idleCycles(CLR_DEPTH + 150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
